// File: rtl/data_memory_sized.sv
// Purpose  : byte-addressed big-endian data memory for the MEM stage, with
//            byte/half/word accesses, optional sign extension and error
//            reporting for misaligned, out-of-range or malformed requests.
// Latency  : WAIT_CYCLES+1 cycles from accept to the one-cycle ready pulse.
// Backpres.: a single access is in flight at a time; requests are sampled only
//            in IDLE (busy low) and ignored otherwise.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   mem_read/mem_write request strobes, sampled in IDLE
//   size, sign_ext    access size (00 B, 01 H, 10 W, 11 reserved), read sign ext
//   address, data     byte address and right-aligned write data
//   mem_result        registered read result (0 on a rejected access)
//   ready, busy       completion pulse, access-in-flight flag
//   error             qualified by ready: access rejected
module data_memory_sized #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned DEPTH_BYTES = 256,  // power of two, >= 4
  parameter int unsigned WAIT_CYCLES = 0     // 0..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] address,
  input  logic [31:0] data,
  output logic [31:0] mem_result,
  output logic        ready,
  output logic        busy,
  output logic        error
);

  localparam int AW = $clog2(DEPTH_BYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic        rd_q;
  logic        wr_q;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;
  logic [7:0]  mem_q [DEPTH_BYTES];

  logic accept;
  logic commit;

  assign accept = (state_q == S_IDLE) && (mem_read || mem_write);
  assign commit = (state_q == S_WAIT) && (cnt_q == 4'd0);

  // ---------------------------------------------------------------------------
  // Access decode, all from the captured request
  // ---------------------------------------------------------------------------
  logic [31:0] idx;
  logic [2:0]  nbytes;
  logic [32:0] end_idx;
  logic        size_err;
  logic        dir_err;
  logic        align_err;
  logic        range_err;
  logic        acc_err;

  // Wrap-around subtraction: addresses below the base become huge indices
  // and fall out of range naturally.
  assign idx = addr_q - 32'(BASE_ADDR);

  always_comb begin
    nbytes = 3'd4;
    case (size_q)
      SZ_BYTE: nbytes = 3'd1;
      SZ_HALF: nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  // One extra bit so index + length cannot overflow past the compare.
  assign end_idx   = {1'b0, idx} + 33'(nbytes);
  assign size_err  = (size_q == 2'b11);
  assign dir_err   = rd_q && wr_q;
  assign align_err = ((size_q == SZ_HALF) && idx[0]) ||
                     ((size_q == SZ_WORD) && (idx[1:0] != 2'b00));
  assign range_err = end_idx > 33'(DEPTH_BYTES);
  assign acc_err   = size_err || dir_err || align_err || range_err;

  // Byte lanes in big-endian order: lane 0 is the byte at idx (MSB of word).
  // Aligned accesses never cross the top of storage once range_err is clear,
  // so the AW-bit wrap of these adds only matters for rejected accesses.
  logic [AW-1:0] i0, i1, i2, i3;
  logic [7:0]    b0, b1, b2, b3;

  assign i0 = idx[AW-1:0];
  assign i1 = i0 + AW'(1);
  assign i2 = i0 + AW'(2);
  assign i3 = i0 + AW'(3);
  assign b0 = mem_q[i0];
  assign b1 = mem_q[i1];
  assign b2 = mem_q[i2];
  assign b3 = mem_q[i3];

  logic [31:0] rdata;

  always_comb begin
    rdata = 32'd0;
    case (size_q)
      SZ_BYTE: rdata = {{24{sext_q & b0[7]}}, b0};
      SZ_HALF: rdata = {{16{sext_q & b0[7]}}, b0, b1};
      default: rdata = {b0, b1, b2, b3};
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM and response registers
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_WAIT;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
          err_d   = acc_err;
          if (acc_err) begin
            result_d = 32'd0;
          end else if (!wr_q) begin
            result_d = rdata;
          end
          // a successful write leaves the previous result in place
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      result_q <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Request capture: only these copies are used once the access is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= address;
      wdata_q <= data;
      size_q  <= size;
      sext_q  <= sign_ext;
      rd_q    <= mem_read;
      wr_q    <= mem_write;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: reset clears every byte; a write commits only on the final WAIT
  // cycle, so a reset during WAIT discards it.
  // ---------------------------------------------------------------------------
  logic do_write;
  assign do_write = commit && wr_q && !acc_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH_BYTES); k++) begin
        mem_q[k] <= 8'd0;
      end
    end else if (do_write) begin
      case (size_q)
        SZ_BYTE: begin
          mem_q[i0] <= wdata_q[7:0];
        end
        SZ_HALF: begin
          mem_q[i0] <= wdata_q[15:8];
          mem_q[i1] <= wdata_q[7:0];
        end
        default: begin
          mem_q[i0] <= wdata_q[31:24];
          mem_q[i1] <= wdata_q[23:16];
          mem_q[i2] <= wdata_q[15:8];
          mem_q[i3] <= wdata_q[7:0];
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_result = result_q;
  assign ready      = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign error      = ready && err_q;

endmodule

// File: doc/data_memory_sized.md
# data_memory_sized

Parametrised, multi-cycle data memory for the ARM datapath's MEM stage. Byte-addressed, big-endian storage mapped at a configurable base address. Supports byte, halfword and word accesses with optional sign extension, a programmable access latency behind a request/ready handshake, and error signalling for misaligned or out-of-range accesses. It replaces the fixed 256-byte, word-only, combinational-read data memory.

## Interface
- BASE_ADDR, 1024: byte address mapped to storage index 0.
- DEPTH_BYTES, 256: storage size in bytes; must be a power of two, at least 4.
- WAIT_CYCLES, 0: extra wait states per access, 0..15.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- mem_read  input  1  read request, sampled in IDLE.
- mem_write  input  1  write request, sampled in IDLE.
- size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved (error).
- sign_ext  input  1  reads only: sign-extend byte/halfword results.
- address  input  32  byte address.
- data  input  32  write data, right-aligned (byte in [7:0], half in [15:0]).
- mem_result  output  32  read result, registered.
- ready  output  1  one-cycle pulse: access complete.
- busy  output  1  high while a request is in flight (not IDLE).
- error  output  1  valid with ready: access rejected.

## Operation
- index = address - BASE_ADDR, computed in 32-bit with wrap-around. Addresses below BASE_ADDR wrap to large values and are out of range.
- Big-endian layout: the byte at index is most significant. A word is {m[i],m[i+1],m[i+2],m[i+3]}; a halfword is {m[i],m[i+1]}.
- The access is rejected (error = 1) if any of these hold:
  - size == 11;
  - mem_read and mem_write are both high;
  - halfword with index[0] != 0;
  - word with index[1:0] != 0;
  - index + access bytes > DEPTH_BYTES.
- A rejected access still completes the handshake. Memory is unchanged and mem_result is 0.
- Read result:
  - word: stored value;
  - byte/half with sign_ext = 1: upper bits filled with bit 7 / bit 15;
  - byte/half with sign_ext = 0: zero-filled.
- Write: only the addressed bytes change; mem_result holds its previous value.
- FSM:
  - IDLE: if mem_read or mem_write is high, capture address, data, size, sign_ext and direction; load cnt = WAIT_CYCLES; go to WAIT.
  - WAIT: if cnt != 0, decrement cnt. If cnt == 0, perform the access (commit the write or load mem_result), set error, go to RESP.
  - RESP: ready = 1 for exactly one cycle, then IDLE.
- Inputs are ignored outside IDLE. Only captured values are used; changes while busy have no effect.
- busy = 1 in WAIT and RESP. ready and error are 0 outside RESP.
- Reset, asynchronous at any time:
  - state goes to IDLE;
  - every memory byte is cleared to 0;
  - mem_result, ready, busy, error, cnt are cleared to 0.
- Reset mid-operation aborts the access. A pending write is not committed.

## Timing
- Request accepted at edge N (state IDLE).
- The access takes effect at edge N+1+WAIT_CYCLES.
- ready/error/mem_result are valid during the cycle after that edge.
- Latency: WAIT_CYCLES+1 cycles from accept to ready.
- Minimum request spacing: WAIT_CYCLES+3 edges (the next accept can occur in the cycle after RESP).
- busy rises the cycle after accept and falls with the end of RESP.
- A request held high continuously is re-accepted on each return to IDLE. The issuer must drop it on ready.

## Test plan
- Reset, then word write 0x00000055 at 1024, then word read at 1024:
  - mem_result = 0x00000055;
  - byte 1027 = 0x55, bytes 1024..1026 = 0;
  - error = 0.
- Byte write 0xA5 at 1029:
  - byte read at 1029 with sign_ext = 1 gives 0xFFFFFFA5; with sign_ext = 0 gives 0x000000A5;
  - word read at 1028 gives 0x00A50000.
- Half write 0x8001 at 1030, then half read with sign_ext = 1:
  - result = 0xFFFF8001;
  - word read at 1026 gives error = 1 and mem_result = 0;
  - memory unchanged.
- Out-of-range accesses, each giving error = 1 with memory unchanged:
  - word write at 1280;
  - word write at 1020;
  - word at 1276 is in range and succeeds.
- With WAIT_CYCLES = 3:
  - ready rises exactly 4 cycles after accept;
  - address/data toggled while busy do not affect the result;
  - both request inputs high gives error = 1.
- Assert rst during WAIT of a word write of 0xDEADBEEF at 1040:
  - memory stays all-zero;
  - ready stays 0;
  - busy drops immediately;
  - a following read of 1040 returns 0.
